multicycle_control: RTL and testbench

// Multi-cycle RV32I main controller; replaces the single-cycle decoder so one shared memory port and ALU serve fetch, address and data phases.
// FSM sequences fetch/decode/execute/writeback, produces all datapath selects, and waits on a memory ready handshake.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/writeback over one shared
// memory port and ALU, producing every datapath select and honouring a memory ready handshake.
module multicycle_control #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       alu_zero,
    input  logic       alu_last_bit,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_source,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_source,
    output logic [2:0] imm_source,
    output logic [3:0] alu_control,
    output logic       illegal_instr,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI = 4'd7,
                           S_ALUWB = 4'd8,  S_BRANCH = 4'd9,  S_JAL = 4'd10,   S_JALR = 4'd11,
                           S_LUI = 4'd12,   S_AUIPC = 4'd13,  S_TRAP = 4'd15;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

    logic [3:0] state_q, state_d;
    logic       ready;
    logic       is_store;
    logic       f7_zero, f7_alt;
    logic       dec_illegal;
    logic [3:0] dec_next;
    logic [3:0] exec_alu, br_alu;
    logic       br_take;

    logic       pc_write_c, adr_source_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, illegal_c;
    logic [1:0] src_a_c, src_b_c, result_c;
    logic [2:0] imm_c;
    logic [3:0] alu_c;

    assign ready    = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign is_store = op[5];
    assign f7_zero  = (func7 == 7'b0000000);
    assign f7_alt   = (func7 == 7'b0100000);

    // Opcode dispatch plus the func3/func7 legality rules of the EXECR/EXECI/BRANCH paths.
    always_comb begin
        dec_illegal = 1'b0;
        dec_next    = S_FETCH;
        case (op)
            OP_LOAD, OP_STORE: dec_next = S_MEMADR;
            OP_R: begin
                dec_next    = S_EXECR;
                dec_illegal = !(f7_zero || (f7_alt && (func3 == 3'b000 || func3 == 3'b101)));
            end
            OP_I: begin
                dec_next = S_EXECI;
                if (func3 == 3'b001)      dec_illegal = !f7_zero;
                else if (func3 == 3'b101) dec_illegal = !(f7_zero || f7_alt);
            end
            OP_BR: begin
                dec_next    = S_BRANCH;
                dec_illegal = (func3[2:1] == 2'b01);
            end
            OP_JAL:   dec_next = S_JAL;
            OP_JALR:  dec_next = S_JALR;
            OP_LUI:   dec_next = S_LUI;
            OP_AUIPC: dec_next = S_AUIPC;
            default:  dec_illegal = 1'b1;
        endcase
        if (dec_illegal) dec_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    end

    always_comb begin
        exec_alu = ALU_ADD;
        case (func3)
            3'b000:  exec_alu = (op == OP_R && f7_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  exec_alu = ALU_SLL;
            3'b010:  exec_alu = ALU_SLT;
            3'b011:  exec_alu = ALU_SLTU;
            3'b100:  exec_alu = ALU_XOR;
            3'b101:  exec_alu = func7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  exec_alu = ALU_OR;
            default: exec_alu = ALU_AND;
        endcase
    end

    // func3[2] picks the compare flavour, func3[0] inverts the outcome.
    assign br_alu  = func3[2] ? (func3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
    assign br_take = (func3[2] ? alu_last_bit : alu_zero) ^ func3[0];

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        adr_source_c = 1'b0;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        result_c     = 2'b00;
        imm_c        = IMM_I;
        alu_c        = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                src_b_c    = 2'b10;
                result_c   = 2'b10;
                pc_write_c = ready;
                ir_write_c = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                imm_c   = (op == OP_JAL) ? IMM_J : IMM_B;
                state_d = dec_next;
            end
            S_MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                imm_c   = is_store ? IMM_S : IMM_I;
                state_d = is_store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read_c   = 1'b1;
                adr_source_c = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                result_c    = 2'b01;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_c  = 1'b1;
                adr_source_c = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                src_a_c = 2'b10;
                src_b_c = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_c   = exec_alu;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c    = 2'b10;
                alu_c      = br_alu;
                pc_write_c = br_take;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = S_JAL;
            end
            S_LUI, S_AUIPC: begin
                src_a_c = (state_q == S_LUI) ? 2'b11 : 2'b01;
                src_b_c = 2'b01;
                imm_c   = IMM_U;
                state_d = S_ALUWB;
            end
            S_TRAP:  illegal_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Reset forces every output low combinationally so an aborted access issues nothing.
    assign pc_write      = pc_write_c   & ~rst;
    assign adr_source    = adr_source_c & ~rst;
    assign ir_write      = ir_write_c   & ~rst;
    assign mem_read      = mem_read_c   & ~rst;
    assign mem_write     = mem_write_c  & ~rst;
    assign reg_write     = reg_write_c  & ~rst;
    assign illegal_instr = illegal_c    & ~rst;
    assign alu_src_a     = rst ? 2'b00 : src_a_c;
    assign alu_src_b     = rst ? 2'b00 : src_b_c;
    assign result_source = rst ? 2'b00 : result_c;
    assign imm_source    = rst ? 3'b000 : imm_c;
    assign alu_control   = rst ? 4'b0000 : alu_c;
    assign state         = rst ? 4'b0000 : state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected phase traces checked every cycle,
// plus literal state-sequence / strobe-count expectations per directed instruction.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op, func7;
    logic [2:0] func3;
    logic       alu_zero, alu_last_bit, mem_ready;
    logic       pc_write, adr_source, ir_write, mem_read, mem_write, reg_write, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, result_source;
    logic [2:0] imm_source;
    logic [3:0] alu_control, state;

    multicycle_control dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_source(adr_source), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_source(result_source),
        .imm_source(imm_source), .alu_control(alu_control),
        .illegal_instr(illegal_instr), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, mr, mw, rw;
        logic [1:0] sa, sb, rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } exp_t;

    exp_t expq[$];
    exp_t dut_vec;
    assign dut_vec = {state, pc_write, adr_source, ir_write, mem_read, mem_write, reg_write,
                      alu_src_a, alu_src_b, result_source, imm_source, alu_control, illegal_instr};

    int compared = 0, mismatched = 0;
    logic [63:0] sig;
    int n_rw, n_pcw, n_mw, n_ill;
    logic [3:0] alu_at [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Single compare process: every driven cycle has an expected record waiting.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("cycle_outputs", 64'(dut_vec), 64'(e));
            sig = {sig[59:0], state};
            n_rw  += int'(reg_write);
            n_pcw += int'(pc_write);
            n_mw  += int'(mem_write);
            n_ill += int'(illegal_instr);
            alu_at[state] = alu_control;
        end
    end

    function automatic exp_t blank(input logic [3:0] s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic [6:0] f7, input bit is_r);
        case (f3)
            3'd0: return (is_r && f7 == 7'h20) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return f7[5] ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic step(input exp_t e, input logic rdy, input logic r);
        rst = r;
        mem_ready = rdy;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_trap();
        exp_t e;
        e = blank(4'd15);
        e.ill = 1'b1;
        for (int i = 0; i < 3; i++) step(e, rnd(), 1'b0);
        step(blank(4'd0), rnd(), 1'b1);
    endtask

    task automatic do_aluwb();
        exp_t e;
        e = blank(4'd8);
        e.rw = 1'b1;
        step(e, rnd(), 1'b0);
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic lb, input int fw, input int mw, input bit abort);
        exp_t e;
        bit legal;
        bit take;
        op = o; func3 = f3; func7 = f7; alu_zero = z; alu_last_bit = lb;
        sig = '0; n_rw = 0; n_pcw = 0; n_mw = 0; n_ill = 0;
        for (int i = 0; i < 16; i++) alu_at[i] = 4'hx;
        $display("instr op=%b f3=%b f7=%b zero=%b last=%b fetch_wait=%0d mem_wait=%0d abort=%0d",
                 o, f3, f7, z, lb, fw, mw, abort);
        e = blank(4'd0); e.mr = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
        for (int i = 0; i < fw; i++) step(e, 1'b0, 1'b0);
        e.pcw = 1'b1; e.irw = 1'b1;
        step(e, 1'b1, 1'b0);
        e = blank(4'd1); e.sa = 2'b01; e.sb = 2'b01; e.imm = (o == OP_JAL) ? 3'd3 : 3'd2;
        step(e, rnd(), 1'b0);
        case (o)
            OP_LOAD, OP_STORE: begin
                e = blank(4'd2); e.sa = 2'b10; e.sb = 2'b01; e.imm = (o == OP_STORE) ? 3'd1 : 3'd0;
                step(e, rnd(), 1'b0);
                if (o == OP_LOAD) begin
                    e = blank(4'd3); e.mr = 1'b1; e.adr = 1'b1;
                    if (abort) begin
                        step(e, 1'b0, 1'b0);
                        step(blank(4'd0), rnd(), 1'b1);
                        return;
                    end
                    for (int i = 0; i < mw; i++) step(e, 1'b0, 1'b0);
                    step(e, 1'b1, 1'b0);
                    e = blank(4'd4); e.rw = 1'b1; e.rs = 2'b01;
                    step(e, rnd(), 1'b0);
                end else begin
                    e = blank(4'd5); e.mw = 1'b1; e.adr = 1'b1;
                    for (int i = 0; i < mw; i++) step(e, 1'b0, 1'b0);
                    step(e, 1'b1, 1'b0);
                end
            end
            OP_R, OP_I: begin
                if (o == OP_R)
                    legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                else if (f3 == 3'd1)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'd5)
                    legal = (f7 == 7'h00 || f7 == 7'h20);
                else
                    legal = 1'b1;
                if (!legal) do_trap();
                else begin
                    e = blank((o == OP_R) ? 4'd6 : 4'd7); e.sa = 2'b10;
                    e.sb = (o == OP_R) ? 2'b00 : 2'b01;
                    e.alu = exp_alu(f3, f7, o == OP_R);
                    step(e, rnd(), 1'b0);
                    do_aluwb();
                end
            end
            OP_BR: begin
                if (f3 == 3'd2 || f3 == 3'd3) do_trap();
                else begin
                    e = blank(4'd9); e.sa = 2'b10;
                    e.alu = (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd8 : 4'd9;
                    take = (f3 < 3'd4) ? z : lb;
                    if (f3[0]) take = !take;
                    e.pcw = take;
                    step(e, rnd(), 1'b0);
                end
            end
            OP_JAL, OP_JALR: begin
                if (o == OP_JALR) begin
                    e = blank(4'd11); e.sa = 2'b10; e.sb = 2'b01;
                    step(e, rnd(), 1'b0);
                end
                e = blank(4'd10); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
                step(e, rnd(), 1'b0);
                do_aluwb();
            end
            OP_LUI, OP_AUIPC: begin
                e = blank((o == OP_LUI) ? 4'd12 : 4'd13);
                e.sa = (o == OP_LUI) ? 2'b11 : 2'b01; e.sb = 2'b01; e.imm = 3'd4;
                step(e, rnd(), 1'b0);
                do_aluwb();
            end
            default: do_trap();
        endcase
    endtask

    initial begin
        rst = 1'b1; op = '0; func3 = '0; func7 = '0;
        alu_zero = 1'b0; alu_last_bit = 1'b0; mem_ready = 1'b0;
        sig = '0;
        @(posedge clk);
        #1;
        step(blank(4'd0), 1'b1, 1'b1);
        step(blank(4'd0), 1'b0, 1'b1);

        run(OP_LOAD, 3'd2, 7'h00, 0, 0, 0, 0, 0);
        chk("lw_states", sig, 64'h01234);
        chk("lw_reg_writes", 64'(n_rw), 64'd1);

        run(OP_STORE, 3'd2, 7'h00, 0, 0, 0, 3, 0);
        chk("sw_states", sig, 64'h0125555);
        chk("sw_mem_write_cycles", 64'(n_mw), 64'd4);
        chk("sw_reg_writes", 64'(n_rw), 64'd0);

        run(OP_BR, 3'd0, 7'h00, 1, 0, 0, 0, 0);
        chk("beq_taken_states", sig, 64'h019);
        chk("beq_taken_pc_writes", 64'(n_pcw), 64'd2);
        chk("beq_alu", 64'(alu_at[9]), 64'd1);

        run(OP_BR, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        chk("beq_not_taken_pc_writes", 64'(n_pcw), 64'd1);

        run(OP_BR, 3'd6, 7'h00, 0, 1, 0, 0, 0);
        chk("bltu_alu", 64'(alu_at[9]), 64'd9);
        chk("bltu_pc_writes", 64'(n_pcw), 64'd2);

        run(OP_BR, 3'd5, 7'h00, 0, 1, 0, 0, 0);
        chk("bge_pc_writes", 64'(n_pcw), 64'd1);

        run(OP_R, 3'd0, 7'h20, 0, 0, 0, 0, 0);
        chk("sub_alu", 64'(alu_at[6]), 64'd1);

        run(OP_I, 3'd5, 7'h20, 0, 0, 0, 0, 0);
        chk("srai_alu", 64'(alu_at[7]), 64'd7);

        run(OP_I, 3'd4, 7'h00, 0, 0, 2, 0, 0);
        chk("xori_wait_states", sig, 64'h000178);

        run(OP_R, 3'd7, 7'h00, 0, 0, 0, 0, 0);
        chk("and_alu", 64'(alu_at[6]), 64'd2);

        run(OP_JALR, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        chk("jalr_states", sig, 64'h01BA8);
        chk("jalr_pc_writes", 64'(n_pcw), 64'd2);
        chk("jalr_reg_writes", 64'(n_rw), 64'd1);

        run(OP_JAL, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        chk("jal_states", sig, 64'h01A8);
        run(OP_LUI, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        chk("lui_states", sig, 64'h01C8);
        run(OP_AUIPC, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        chk("auipc_states", sig, 64'h01D8);

        run(OP_LOAD, 3'd2, 7'h00, 0, 0, 0, 0, 1);
        chk("lw_abort_states", sig, 64'h01230);
        chk("lw_abort_reg_writes", 64'(n_rw), 64'd0);

        run(OP_R, 3'd0, 7'h01, 0, 0, 0, 0, 0);
        chk("r_bad_f7_states", sig, 64'h01FFF0);
        chk("r_bad_f7_illegal_cycles", 64'(n_ill), 64'd3);

        run(7'b1110011, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        chk("ecall_states", sig, 64'h01FFF0);
        run(OP_I, 3'd1, 7'h20, 0, 0, 0, 0, 0);
        chk("slli_bad_states", sig, 64'h01FFF0);
        run(OP_BR, 3'd2, 7'h00, 0, 0, 0, 0, 0);
        chk("branch_bad_f3_states", sig, 64'h01FFF0);

        run(OP_LOAD, 3'd2, 7'h00, 0, 0, 1, 2, 0);
        chk("lw_wait_states", sig, 64'h0012333 << 4 | 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
